// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode, bit order, FSM states.
package spi_pkg;

  localparam int DATA_W_DEF = 8;
  localparam bit CPOL       = 1'b0;
  localparam bit CPHA       = 1'b0;
  localparam bit MSB_FIRST  = 1'b1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/spi_responder_if.sv
// Host-side tx/rx byte handshake of the SPI responder.
interface spi_responder_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall event outputs.
module spi_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              q;
  logic              q_d;

  assign q = sr[STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= {STAGES{RST_VAL}};
      q_d <= RST_VAL;
    end else begin
      sr  <= {sr[STAGES-2:0], d};
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder in the clk domain.
// Optional SPI_RESPONDER_STATUS_EN adds sticky error flags.
module spi_responder
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
`ifdef SPI_RESPONDER_STATUS_EN
  input  logic status_clr,
  output logic err_underrun,
  output logic err_abort,
`endif
  spi_responder_if.slave bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift;
  logic [DATA_W-1:0] rx_next, tx_next;
  logic [DATA_W-1:0] buf_data, rx_data_q;
  logic              buf_full, reload_pending;
  logic              rx_valid_q;
  logic              sclk_rise, sclk_fall;
  logic              cs_rise, cs_fall;
  logic              sample_ev, shift_ev;
  logic              smp, shf, do_load, leave;
  logic              tx_bit, accept;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic              mosi_s;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(CPOL)
  ) u_sclk (
    .clk (clk),
    .rst (rst),
    .d   (sclk),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk (clk),
    .rst (rst),
    .d   (cs_n),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  // Same depth as sclk so mosi is sampled at matching age
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sr <= '0;
    else      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sample_ev = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
  assign shift_ev  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;

  assign tx_bit  = MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0];
  assign rx_next = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s}
                             : {mosi_s, rx_shift[DATA_W-1:1]};
  assign tx_next = MSB_FIRST ? {tx_shift[DATA_W-2:0], 1'b0}
                             : {1'b0, tx_shift[DATA_W-1:1]};

  assign accept       = bus.tx_valid & ~buf_full;
  assign bus.tx_ready = ~buf_full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    leave     = 1'b0;
    smp       = 1'b0;
    shf       = 1'b0;
    miso_oe   = 1'b0;
    miso      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          do_load   = 1'b1;
        end
      end
      SHIFT: begin
        miso_oe = 1'b1;
        miso    = tx_bit;
        if (cs_rise) begin
          state_nxt = IDLE;
          leave     = 1'b1;
        end else begin
          smp     = sample_ev;
          shf     = shift_ev & ~reload_pending;
          do_load = shift_ev & reload_pending;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      buf_data       <= '0;
      buf_full       <= 1'b0;
      reload_pending <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (do_load)  tx_shift <= buf_full ? buf_data : '0;
      else if (shf) tx_shift <= tx_next;
      if (do_load || leave) reload_pending <= 1'b0;
      if (leave) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (do_load && state == IDLE) begin
        bit_cnt <= '0;
      end else if (smp) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST) begin
          bit_cnt        <= '0;
          rx_data_q      <= rx_next;
          rx_valid_q     <= 1'b1;
          reload_pending <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      // An empty-buffer load sends 0; a same-cycle accept stays buffered
      if (do_load && buf_full) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
        buf_data <= bus.tx_data;
      end
    end
  end

`ifdef SPI_RESPONDER_STATUS_EN
  logic underrun, abort;

  assign underrun = do_load & ~buf_full;
  assign abort    = leave & (bit_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underrun <= 1'b0;
      err_abort    <= 1'b0;
    end else begin
      if (underrun)        err_underrun <= 1'b1;
      else if (status_clr) err_underrun <= 1'b0;
      if (abort)           err_abort <= 1'b1;
      else if (status_clr) err_abort <= 1'b0;
    end
  end
`endif

endmodule
